// File: rtl/array_mem_loader.sv
// Loader stage ahead of the summing loop: zero-fills the array memory, stores switch bytes on
// load edges, then hands the memory port to the loop FSM until a clear edge reclaims it.
module array_mem_loader #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_in_i,
    input  logic              load_req_i,
    input  logic              go_req_i,
    input  logic              clr_req_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic              mem_wren_o,
    output logic              owns_mem_o,
    output logic              loop_start_o,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic [2:0]        state_dbg_o
);

    localparam logic [ADDR_W:0]   FullCount = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        StClear   = 3'd0,
        StLoad    = 3'd1,
        StHandoff = 3'd2,
        StWait    = 3'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              go_pend_q, go_pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wren_q, wren_d;
    logic              owns_q, owns_d;
    logic              start_q, start_d;
    logic              full_q, full_d;

    // [0],[1] synchronise the raw level; [2] holds the previous synchronised value.
    logic [2:0] load_sync_q, go_sync_q, clr_sync_q;
    logic       load_edge, go_edge, clr_edge;

    assign load_edge = load_sync_q[1] & ~load_sync_q[2];
    assign go_edge   = go_sync_q[1] & ~go_sync_q[2];
    assign clr_edge  = clr_sync_q[1] & ~clr_sync_q[2];

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        count_d   = count_q;
        go_pend_d = go_pend_q;
        addr_d    = addr_q;
        din_d     = din_q;
        wren_d    = 1'b0;
        owns_d    = owns_q;
        start_d   = 1'b0;

        case (state_q)
            StClear: begin
                addr_d = clr_cnt_q;
                din_d  = '0;
                wren_d = 1'b1;
                owns_d = 1'b1;
                if (clr_cnt_q == LastAddr) begin
                    state_d   = StLoad;
                    count_d   = '0;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            StLoad: begin
                if (clr_edge) begin
                    state_d   = StClear;
                    count_d   = '0;
                    clr_cnt_d = '0;
                    go_pend_d = 1'b0;
                end else if (go_pend_q || count_q == FullCount) begin
                    // Handoff waits one cycle behind the final write so that write lands.
                    state_d   = StHandoff;
                    start_d   = 1'b1;
                    owns_d    = 1'b0;
                    go_pend_d = 1'b0;
                end else if (load_edge) begin
                    addr_d    = count_q[ADDR_W-1:0];
                    din_d     = data_in_i;
                    wren_d    = 1'b1;
                    count_d   = count_q + 1'b1;
                    go_pend_d = go_edge;
                end else if (go_edge) begin
                    state_d = StHandoff;
                    start_d = 1'b1;
                    owns_d  = 1'b0;
                end
            end
            StHandoff: begin
                owns_d  = 1'b0;
                state_d = StWait;
            end
            StWait: begin
                owns_d = 1'b0;
                if (clr_edge) begin
                    state_d   = StClear;
                    owns_d    = 1'b1;
                    count_d   = '0;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = StClear;
                clr_cnt_d = '0;
                go_pend_d = 1'b0;
            end
        endcase

        full_d = (count_d == FullCount);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StClear;
            clr_cnt_q   <= '0;
            count_q     <= '0;
            go_pend_q   <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            wren_q      <= 1'b0;
            owns_q      <= 1'b1;
            start_q     <= 1'b0;
            full_q      <= 1'b0;
            load_sync_q <= '0;
            go_sync_q   <= '0;
            clr_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            count_q     <= count_d;
            go_pend_q   <= go_pend_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            wren_q      <= wren_d;
            owns_q      <= owns_d;
            start_q     <= start_d;
            full_q      <= full_d;
            load_sync_q <= {load_sync_q[1:0], load_req_i};
            go_sync_q   <= {go_sync_q[1:0], go_req_i};
            clr_sync_q  <= {clr_sync_q[1:0], clr_req_i};
        end
    end

    assign mem_addr_o   = addr_q;
    assign mem_din_o    = din_q;
    assign mem_wren_o   = wren_q;
    assign owns_mem_o   = owns_q;
    assign loop_start_o = start_q;
    assign count_o      = count_q;
    assign full_o       = full_q;
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_array_mem_loader.sv
// Randomised scoreboard bench for array_mem_loader: expected writes and handoffs are queued
// by a word-level model when requests are issued, and a monitor matches them on the bus.
module tb_array_mem_loader;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              load_req = 1'b0;
    logic              go_req = 1'b0;
    logic              clr_req = 1'b0;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_din_o;
    logic              mem_wren_o;
    logic              owns_mem_o;
    logic              loop_start_o;
    logic [ADDR_W:0]   count_o;
    logic              full_o;
    logic [2:0]        state_dbg_o;

    array_mem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_in_i   (data_in),
        .load_req_i  (load_req),
        .go_req_i    (go_req),
        .clr_req_i   (clr_req),
        .mem_addr_o  (mem_addr_o),
        .mem_din_o   (mem_din_o),
        .mem_wren_o  (mem_wren_o),
        .owns_mem_o  (owns_mem_o),
        .loop_start_o(loop_start_o),
        .count_o     (count_o),
        .full_o      (full_o),
        .state_dbg_o (state_dbg_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    int                exp_ls_q[$];

    logic [DATA_W-1:0] obs_mem[DEPTH];
    logic [DATA_W-1:0] ref_mem[DEPTH];
    int                ref_count = 0;
    bit                ref_handed = 1'b0;
    logic              ls_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every bus write and every start pulse must match the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            chk("wren_in_reset", int'(mem_wren_o), 0);
            ls_prev = 1'b0;
        end else begin
            if (mem_wren_o) begin
                chk("write_owner", int'(owns_mem_o), 1);
                chk("write_expected", int'(exp_addr_q.size() > 0), 1);
                if (exp_addr_q.size() > 0) begin
                    chk("write_addr", int'(mem_addr_o), int'(exp_addr_q.pop_front()));
                    chk("write_data", int'(mem_din_o), int'(exp_data_q.pop_front()));
                end
                obs_mem[mem_addr_o] = mem_din_o;
            end
            if (loop_start_o) begin
                chk("start_owner", int'(owns_mem_o), 0);
                chk("start_width", int'(ls_prev), 0);
                chk("start_expected", int'(exp_ls_q.size() > 0), 1);
                if (exp_ls_q.size() > 0) chk("start_count", int'(count_o), exp_ls_q.pop_front());
            end
            ls_prev = loop_start_o;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input bit l, input bit g, input bit c, input logic [DATA_W-1:0] d);
        data_in  = d;
        load_req = l;
        go_req   = g;
        clr_req  = c;
        tick(4);
        load_req = 1'b0;
        go_req   = 1'b0;
        clr_req  = 1'b0;
        tick(4);
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back('0);
            ref_mem[i] = '0;
        end
        ref_count  = 0;
        ref_handed = 1'b0;
    endtask

    task automatic check_image();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) if (obs_mem[i] !== ref_mem[i]) bad++;
        chk("mem_image_mismatches", bad, 0);
    endtask

    task automatic check_status();
        chk("count", int'(count_o), ref_count);
        chk("full", int'(full_o), int'(ref_count == DEPTH));
        chk("owns_mem", int'(owns_mem_o), int'(!ref_handed));
        chk("state", int'(state_dbg_o), ref_handed ? 3 : 1);
    endtask

    task automatic op(input bit l, input bit g, input bit c, input logic [DATA_W-1:0] d);
        bit handed_now = 1'b0;
        if (c) begin
            model_clear();
            pulse(1'b0, 1'b0, 1'b1, d);
            tick(36);
        end else begin
            if (!ref_handed) begin
                if (l && ref_count < DEPTH) begin
                    exp_addr_q.push_back(ADDR_W'(ref_count));
                    exp_data_q.push_back(d);
                    ref_mem[ref_count] = d;
                    ref_count++;
                end
                if (g || ref_count == DEPTH) begin
                    exp_ls_q.push_back(ref_count);
                    ref_handed = 1'b1;
                    handed_now = 1'b1;
                end
            end
            pulse(l, g, 1'b0, d);
            if (handed_now) check_image();
        end
        check_status();
    endtask

    initial begin
        bit found;
        int r;
        for (int i = 0; i < DEPTH; i++) begin
            obs_mem[i] = 'x;
            ref_mem[i] = '0;
        end
        #1 rst = 1'b1;
        tick(3);
        chk("rst_state", int'(state_dbg_o), 0);
        chk("rst_wren", int'(mem_wren_o), 0);
        chk("rst_owns", int'(owns_mem_o), 1);
        chk("rst_count", int'(count_o), 0);
        chk("rst_full", int'(full_o), 0);
        chk("rst_start", int'(loop_start_o), 0);
        chk("rst_addr", int'(mem_addr_o), 0);

        // Zero-fill after release, then LOAD with nothing stored.
        model_clear();
        rst = 1'b0;
        tick(40);
        check_status();

        // Three signed bytes, hand off early, stray load ignored.
        op(1'b1, 1'b0, 1'b0, 8'h03);
        op(1'b1, 1'b0, 1'b0, 8'hF9);
        op(1'b1, 1'b0, 1'b0, 8'h7F);
        op(1'b0, 1'b1, 1'b0, 8'h00);
        op(1'b1, 1'b0, 1'b0, 8'h55);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // Reclaim from WAIT, then fill to the top; the extra load must not write.
        op(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < DEPTH + 1; i++) op(1'b1, 1'b0, 1'b0, 8'h01);

        // Simultaneous load and go at count 4.
        op(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 4; i++) op(1'b1, 1'b0, 1'b0, 8'(i + 16));
        op(1'b1, 1'b1, 1'b0, 8'h80);

        // Go with nothing loaded hands off an all-zero array.
        op(1'b0, 1'b0, 1'b1, 8'h00);
        op(1'b0, 1'b1, 1'b0, 8'h00);

        // Reset in the middle of a zero-fill.
        model_clear();
        pulse(1'b0, 1'b0, 1'b1, 8'h00);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick(1);
            if (mem_wren_o && mem_addr_o == ADDR_W'(10)) found = 1'b1;
        end
        chk("reached_clear_addr10", int'(found), 1);
        rst = 1'b1;
        #1;
        chk("midrst_wren", int'(mem_wren_o), 0);
        chk("midrst_state", int'(state_dbg_o), 0);
        exp_addr_q.delete();
        exp_data_q.delete();
        tick(3);
        model_clear();
        rst = 1'b0;
        tick(40);
        check_status();

        // Random mix of loads, goes, clears and combined load+go.
        for (int n = 0; n < 90; n++) begin
            r = $urandom_range(0, 99);
            if (r < 62)      op(1'b1, 1'b0, 1'b0, 8'($urandom));
            else if (r < 72) op(1'b0, 1'b1, 1'b0, 8'($urandom));
            else if (r < 80) op(1'b0, 1'b0, 1'b1, 8'($urandom));
            else if (r < 88) op(1'b1, 1'b1, 1'b0, 8'($urandom));
            else             op(1'b1, 1'b0, 1'b0, 8'($urandom));
        end

        for (int k = 0; k < 100 && (exp_addr_q.size() > 0 || exp_ls_q.size() > 0); k++) tick(1);
        chk("writes_outstanding", exp_addr_q.size(), 0);
        chk("starts_outstanding", exp_ls_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
